// File: rtl/uart_pkg.sv
// Shared UART types: parity selection and framing states.
// Imported by the transmit engine and reusable by the receive side.
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP_BIT  = 3'd4
   } uart_state_e;

   // Zero-extended payload; padding bits do not change the XOR.
   function automatic logic parity_bit(input logic [8:0] data,
                                       input parity_e    mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bit_done on the last clk of each bit.
// Held at zero while restart is high so a frame starts on a clean period.
module uart_baud_gen #(
   parameter int BAUD_DIVISOR = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_done
);

   localparam int CW = (BAUD_DIVISOR > 2) ? $clog2(BAUD_DIVISOR) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIVISOR - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_done = (cnt_q == LAST);

   // Count clks within a bit; wrap to 0 on every bit boundary.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || bit_done) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start, LSB-first data, optional parity, 1-2 stops.
// tx is registered; a frame is latched on the valid/ready handshake.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int      BAUD_DIVISOR = 1024,
   parameter int      FRAME_SIZE   = 8,
   parameter parity_e PARITY_MODE  = PARITY_NONE,
   parameter int      STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FRAME_SIZE-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx,
   output logic                  busy
);

   localparam int BW = $clog2(FRAME_SIZE + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_SIZE);
   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   if (BAUD_DIVISOR < 2) begin : g_bad_baud
      $fatal(1, "uart_tx_engine: BAUD_DIVISOR must be >= 2");
   end
   if (FRAME_SIZE < 5 || FRAME_SIZE > 9) begin : g_bad_frame
      $fatal(1, "uart_tx_engine: FRAME_SIZE must be 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $fatal(1, "uart_tx_engine: STOP_BITS must be 1 or 2");
   end
   if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN &&
       PARITY_MODE != PARITY_ODD) begin : g_bad_parity
      $fatal(1, "uart_tx_engine: illegal PARITY_MODE");
   end

   uart_state_e           state_q;
   uart_state_e           state_d;
   logic [FRAME_SIZE-1:0] shift_q;
   logic [FRAME_SIZE-1:0] shift_d;
   logic [BW-1:0]         bit_cnt_q;
   logic [BW-1:0]         bit_cnt_d;
   logic                  stop_cnt_q;
   logic                  stop_cnt_d;
   logic                  parity_q;
   logic                  parity_d;
   logic                  tx_q;
   logic                  tx_d;
   logic                  bit_done;

   assign tx_ready = (state_q == IDLE) && !rst;
   assign busy     = (state_q != IDLE);
   assign tx       = tx_q;

   uart_baud_gen #(
      .BAUD_DIVISOR(BAUD_DIVISOR)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .restart (state_q == IDLE),
      .bit_done(bit_done)
   );

   // Framing FSM: next state, shift/count updates and next tx level.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      parity_d   = parity_q;
      tx_d       = tx_q;
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (tx_valid) begin
               state_d    = START_BIT;
               shift_d    = tx_data;
               parity_d   = parity_bit(9'(tx_data), PARITY_MODE);
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
               tx_d       = 1'b0;
            end
         end
         START_BIT: begin
            if (bit_done) begin
               state_d   = DATA;
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = BW'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_cnt_q == LAST_BIT) begin
                  if (PARITY_MODE != PARITY_NONE) begin
                     state_d = PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = STOP_BIT;
                     tx_d    = 1'b1;
                  end
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_d = STOP_BIT;
               tx_d    = 1'b1;
            end
         end
         STOP_BIT: begin
            tx_d = 1'b1;
            if (bit_done) begin
               if (stop_cnt_q == STOP_LAST) begin
                  state_d = IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four configurations against a frame-level
// waveform model, plus literal checks on timing and parity.
module tb_uart_tx_engine;
   import uart_pkg::*;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_valid;
   logic [8:0] tx_data;
   logic       chk_en = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   logic [N-1:0] dut_tx_v, dut_busy_v, dut_rdy_v;
   logic [N-1:0] exp_tx_v, exp_busy_v, exp_idle_v;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic par(input logic [8:0] d, input int fs,
                                input int pm);
      logic p = 1'b0;
      for (int i = 0; i < fs; i++) p ^= d[i];
      if (pm == 2) p = ~p;
      return p;
   endfunction

   // Frame as a bit list, bit 0 first on the line.
   function automatic logic [15:0] build(input logic [8:0] d, input int fs,
                                         input int pm, input int sb,
                                         output int nb);
      logic [15:0] f = '0;
      int n = 1;
      for (int i = 0; i < fs; i++) begin
         f[n] = d[i];
         n++;
      end
      if (pm != 0) begin
         f[n] = par(d, fs, pm);
         n++;
      end
      for (int s = 0; s < sb; s++) begin
         f[n] = 1'b1;
         n++;
      end
      nb = n;
      return f;
   endfunction

   task automatic chk(input string nm, input int g, input logic a,
                      input logic e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s inst%0d @%0t got %b want %b", nm, g, $time, a, e);
      end
   endtask

   task automatic chk_int(input string nm, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, a, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < N; g++) begin : g_inst
      localparam int DIV = (g == 2) ? 3 : 4;
      localparam int FS  = (g == 3) ? 5 : 8;
      localparam int PM  = (g == 1) ? 1 : (g == 2) ? 2 : 0;
      localparam int SB  = (g >= 2) ? 2 : 1;
      localparam parity_e PME = parity_e'(PM);

      logic tx_w, busy_w, rdy_w;

      uart_tx_engine #(
         .BAUD_DIVISOR(DIV),
         .FRAME_SIZE  (FS),
         .PARITY_MODE (PME),
         .STOP_BITS   (SB)
      ) u_dut (
         .clk     (clk),
         .rst     (rst),
         .tx_data (tx_data[FS-1:0]),
         .tx_valid(tx_valid),
         .tx_ready(rdy_w),
         .tx      (tx_w),
         .busy    (busy_w)
      );

      // t = clks since acceptance (0 = idle); line = frame bit t-1 / DIV.
      int          t = 0;
      int          nb = 1;
      logic [15:0] fr = '1;
      int          idx;

      always @(posedge clk) begin
         if (rst) t = 0;
         else if (t == 0) begin
            if (tx_valid) begin
               fr = build(tx_data, FS, PM, SB, nb);
               t = 1;
            end
         end else if (t < nb * DIV) t++;
         else t = 0;
      end

      assign idx           = (t == 0) ? 0 : (t - 1) / DIV;
      assign exp_tx_v[g]   = (t == 0) ? 1'b1 : fr[idx];
      assign exp_busy_v[g] = (t != 0);
      assign exp_idle_v[g] = (t == 0);
      assign dut_tx_v[g]   = tx_w;
      assign dut_busy_v[g] = busy_w;
      assign dut_rdy_v[g]  = rdy_w;
   end

   // Every cycle, every instance: line, busy and ready against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < N; g++) begin
            chk("tx", g, dut_tx_v[g], exp_tx_v[g]);
            chk("busy", g, dut_busy_v[g], exp_busy_v[g]);
            chk("ready", g, dut_rdy_v[g], exp_idle_v[g] & ~rst);
         end
      end
   end

   initial begin
      int cnt[N];
      int nb;
      int last;
      logic prev;
      logic [15:0] f;

      rst = 1'b1;
      tx_valid = 1'b0;
      tx_data = '0;
      tick;
      chk_en = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      @(negedge clk);
      chk_int("ready_after_rst", int'(dut_rdy_v), 4'hF);
      chk_int("busy_after_rst", int'(dut_busy_v), 0);
      chk_int("tx_after_rst", int'(dut_tx_v), 4'hF);

      f = build(9'h0A5, 8, 0, 1, nb);
      chk_int("model_a5_8n1", int'(f), 16'h034A);
      chk_int("model_a5_nbits", nb, 10);
      f = build(9'h01F, 5, 0, 2, nb);
      chk_int("model_1f_5n2", int'(f), 16'h00FE);
      chk_int("model_1f_nbits", nb, 8);
      chk_int("par_even_a5", int'(par(9'h0A5, 8, 1)), 0);
      chk_int("par_odd_07", int'(par(9'h007, 8, 2)), 0);
      chk_int("par_even_07", int'(par(9'h007, 8, 1)), 1);

      tick;
      tx_data = 9'h0A5;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      tx_data = 9'h15A;
      for (int g = 0; g < N; g++) cnt[g] = 0;
      repeat (100) begin
         @(negedge clk);
         for (int g = 0; g < N; g++) if (dut_busy_v[g]) cnt[g]++;
      end
      chk_int("busy_len_8n1", cnt[0], 40);
      chk_int("busy_len_8e1", cnt[1], 44);
      chk_int("busy_len_8o2_div3", cnt[2], 36);
      chk_int("busy_len_5n2", cnt[3], 32);

      tick;
      tx_data = 9'h007;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      repeat (60) tick;

      repeat (3000) begin
         tx_data = 9'($urandom_range(0, 511));
         tx_valid = ($urandom_range(0, 3) == 0);
         tick;
      end
      tx_valid = 1'b0;
      repeat (60) tick;

      tx_valid = 1'b1;
      last = -1;
      prev = dut_busy_v[0];
      repeat (300) begin
         tx_data = 9'($urandom_range(0, 511));
         @(negedge clk);
         if (dut_busy_v[0] && !prev) begin
            if (last >= 0) chk_int("frame_spacing", cyc - last, 41);
            last = cyc;
         end
         prev = dut_busy_v[0];
         @(posedge clk);
         #1;
      end
      tx_valid = 1'b0;
      repeat (60) tick;

      tx_data = 9'h0C3;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      repeat (17) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      @(negedge clk);
      chk_int("abort_tx", int'(dut_tx_v[0]), 1);
      chk_int("abort_busy", int'(dut_busy_v[0]), 0);
      tick;
      tx_data = 9'h03C;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      repeat (60) tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
